// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and default widths used by issue, reservation stations and commit.
package rob_pkg;

    localparam int ROB_DATA_W  = 32;
    localparam int ROB_REG_AW  = 4;
    localparam int ROB_INSTR_W = 32;

    typedef struct packed {
        logic                   busy;
        logic                   done;
        logic [ROB_INSTR_W-1:0] instr;
        logic [ROB_REG_AW-1:0]  dest;
        logic [ROB_DATA_W-1:0]  value;
    } rob_entry_t;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_DEC  = 2'b01,
        CNT_INC  = 2'b10,
        CNT_BOTH = 2'b11
    } rob_cnt_op_e;

    // Encodes allocate/commit activity into the occupancy update to apply.
    function automatic rob_cnt_op_e rob_cnt_op(input logic alloc_fire, input logic commit_fire);
        return rob_cnt_op_e'({alloc_fire, commit_fire});
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around ring pointer for the reorder buffer (head or tail), power-of-two depth.
module rob_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_r;

    // Pointer register: synchronous clear wins over increment; natural wrap at 2**W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (clr) begin
            ptr_r <= '0;
        end else if (inc) begin
            ptr_r <= ptr_r + W'(1);
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/rob_core.sv
// Circular reorder buffer: in-order allocate at tail, CDB capture by tag, in-order commit at head.
// Optional flush input enabled by defining ROB_FLUSH_EN.
module rob_core
    import rob_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = $clog2(DEPTH),
    parameter int DATA_W  = ROB_DATA_W,
    parameter int REG_AW  = ROB_REG_AW,
    parameter int INSTR_W = ROB_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic [INSTR_W-1:0] alloc_instr,
    input  logic [REG_AW-1:0]  alloc_dest,
    output logic [TAG_W-1:0]   alloc_tag,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_value,
    output logic               commit_valid,
    input  logic               commit_ready,
    output logic [TAG_W-1:0]   commit_tag,
    output logic [REG_AW-1:0]  commit_dest,
    output logic [DATA_W-1:0]  commit_value,
    output logic [INSTR_W-1:0] commit_instr,
    output logic [TAG_W:0]     count,
    output logic               empty,
    output logic               full
`ifdef ROB_FLUSH_EN
    ,
    input  logic               flush
`endif
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

    logic [DEPTH-1:0]   busy_r;
    logic [DEPTH-1:0]   done_r;
    logic [INSTR_W-1:0] instr_r [DEPTH];
    logic [REG_AW-1:0]  dest_r  [DEPTH];
    logic [DATA_W-1:0]  value_r [DEPTH];
    logic [TAG_W:0]     count_r;

    logic [TAG_W-1:0]   head_s;
    logic [TAG_W-1:0]   tail_s;
    logic               flush_s;
    logic               alloc_fire_s;
    logic               commit_fire_s;
    logic               cdb_hit_s;

`ifdef ROB_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign full          = (count_r == FULL_CNT);
    assign empty         = (count_r == '0);
    assign count         = count_r;
    assign alloc_ready   = !full;
    assign alloc_tag     = tail_s;
    assign alloc_fire_s  = alloc_valid && !full;
    assign commit_valid  = busy_r[head_s] && done_r[head_s];
    assign commit_fire_s = commit_valid && commit_ready;
    assign cdb_hit_s     = cdb_valid && busy_r[cdb_tag] && !done_r[cdb_tag];

    assign commit_tag    = head_s;
    assign commit_dest   = dest_r[head_s];
    assign commit_value  = value_r[head_s];
    assign commit_instr  = instr_r[head_s];

    rob_ptr #(.W(TAG_W)) u_head (
        .clk (clk),
        .rst (rst),
        .clr (flush_s),
        .inc (commit_fire_s),
        .ptr (head_s)
    );

    rob_ptr #(.W(TAG_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .clr (flush_s),
        .inc (alloc_fire_s),
        .ptr (tail_s)
    );

    // Entry storage and occupancy; a free tail entry can never collide with a CDB hit or the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= '0;
            done_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_r[i] <= '0;
                dest_r[i]  <= '0;
                value_r[i] <= '0;
            end
        end else if (flush_s) begin
            busy_r  <= '0;
            done_r  <= '0;
            count_r <= '0;
        end else begin
            if (cdb_hit_s) begin
                value_r[cdb_tag] <= cdb_value;
                done_r[cdb_tag]  <= 1'b1;
            end
            if (commit_fire_s) begin
                busy_r[head_s] <= 1'b0;
                done_r[head_s] <= 1'b0;
            end
            if (alloc_fire_s) begin
                busy_r[tail_s]  <= 1'b1;
                done_r[tail_s]  <= 1'b0;
                instr_r[tail_s] <= alloc_instr;
                dest_r[tail_s]  <= alloc_dest;
                value_r[tail_s] <= '0;
            end
            case (rob_cnt_op(alloc_fire_s, commit_fire_s))
                CNT_INC: count_r <= count_r + (TAG_W + 1)'(1);
                CNT_DEC: count_r <= count_r - (TAG_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_core.sv
// Self-checking bench for rob_core: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [31:0] alloc_instr = 32'h0;
    logic [3:0]  alloc_dest = 4'h0;
    logic [1:0]  alloc_tag;
    logic        cdb_valid = 1'b0;
    logic [1:0]  cdb_tag = 2'd0;
    logic [31:0] cdb_value = 32'h0;
    logic        commit_valid;
    logic        commit_ready = 1'b0;
    logic [1:0]  commit_tag;
    logic [3:0]  commit_dest;
    logic [31:0] commit_value;
    logic [31:0] commit_instr;
    logic [2:0]  count;
    logic        empty;
    logic        full;
`ifdef ROB_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rob_core dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_instr  (alloc_instr),
        .alloc_dest   (alloc_dest),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_tag   (commit_tag),
        .commit_dest  (commit_dest),
        .commit_value (commit_value),
        .commit_instr (commit_instr),
        .count        (count),
        .empty        (empty),
        .full         (full)
`ifdef ROB_FLUSH_EN
        ,
        .flush        (flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight instructions in program order; tag = position in the ring.
    typedef struct {
        int          tag;
        logic [31:0] instr;
        logic [3:0]  dest;
        logic [31:0] value;
        bit          done;
    } ment_t;

    ment_t q[$];
    int    m_head = 0;

    always @(negedge clk) begin
        ment_t e;
        int    sz;
        int    tail_pre;
        bit    cf;
        bit    af;
        bit    exp_cv;
        if (rst) begin
            q.delete();
            m_head = 0;
        end
        sz     = q.size();
        exp_cv = (sz > 0) && q[0].done;
        check("m_count", 64'(count), 64'(sz));
        check("m_empty", 64'(empty), 64'(sz == 0));
        check("m_full", 64'(full), 64'(sz == 4));
        check("m_alloc_ready", 64'(alloc_ready), 64'(sz < 4));
        check("m_alloc_tag", 64'(alloc_tag), 64'((m_head + sz) % 4));
        check("m_commit_valid", 64'(commit_valid), 64'(exp_cv));
        check("m_count_le4", 64'(count <= 3'd4), 64'(1));
        if (exp_cv) begin
            check("m_commit_tag", 64'(commit_tag), 64'(m_head));
            check("m_commit_dest", 64'(commit_dest), 64'(q[0].dest));
            check("m_commit_value", 64'(commit_value), 64'(q[0].value));
            check("m_commit_instr", 64'(commit_instr), 64'(q[0].instr));
        end
        if (!rst) begin
            tail_pre = (m_head + sz) % 4;
            cf = commit_ready && exp_cv;
            af = alloc_valid && (sz < 4);
`ifdef ROB_FLUSH_EN
            if (flush) begin
                q.delete();
                m_head = 0;
                cf = 1'b0;
                af = 1'b0;
            end
`endif
            if (cdb_valid && (q.size() > 0)) begin
                for (int i = 0; i < sz; i++) begin
                    if (q[i].tag == int'(cdb_tag) && !q[i].done) begin
                        e = q[i];
                        e.value = cdb_value;
                        e.done = 1'b1;
                        q[i] = e;
                    end
                end
            end
            if (cf) begin
                void'(q.pop_front());
                m_head = (m_head + 1) % 4;
            end
            if (af) begin
                e.tag   = tail_pre;
                e.instr = alloc_instr;
                e.dest  = alloc_dest;
                e.value = 32'h0;
                e.done  = 1'b0;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cdb(input logic [1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = val;
        step();
        cdb_valid = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        check("rst_count", 64'(count), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full", 64'(full), 64'(0));
        check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check("rst_alloc_tag", 64'(alloc_tag), 64'(0));
        check("rst_commit_valid", 64'(commit_valid), 64'(0));
        check("rst_commit_value", 64'(commit_value), 64'(0));
        check("rst_commit_instr", 64'(commit_instr), 64'(0));
        rst = 1'b0;
        step();

        // In-order commit with out-of-order completion.
        commit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("io_alloc_tag", 64'(alloc_tag), 64'(i));
            alloc_valid = 1'b1;
            alloc_instr = 32'hA000_0000 + 32'(i);
            alloc_dest  = 4'(i + 1);
            step();
        end
        alloc_valid = 1'b0;
        check("io_count3", 64'(count), 64'(3));
        do_cdb(2'd2, 32'h33);
        check("io_cv_low_head_not_done", 64'(commit_valid), 64'(0));
        do_cdb(2'd0, 32'h11);
        check("io_cv0", 64'(commit_valid), 64'(1));
        check("io_tag0", 64'(commit_tag), 64'(0));
        check("io_val0", 64'(commit_value), 64'(32'h11));
        check("io_dest0", 64'(commit_dest), 64'(1));
        do_cdb(2'd1, 32'h22);
        check("io_tag1", 64'(commit_tag), 64'(1));
        check("io_val1", 64'(commit_value), 64'(32'h22));
        step();
        check("io_tag2", 64'(commit_tag), 64'(2));
        check("io_val2", 64'(commit_value), 64'(32'h33));
        check("io_instr2", 64'(commit_instr), 64'(32'hA000_0002));
        step();
        check("io_empty", 64'(empty), 64'(1));
        commit_ready = 1'b0;

        // Fill to capacity, then try to overfill.
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            alloc_instr = 32'hB000_0000 + 32'(i);
            alloc_dest  = 4'(i + 8);
            step();
        end
        check("full_full", 64'(full), 64'(1));
        check("full_alloc_ready", 64'(alloc_ready), 64'(0));
        step();
        alloc_valid = 1'b0;
        check("full_count_held", 64'(count), 64'(4));
        check("full_tail_held", 64'(alloc_tag), 64'(3));
        do_cdb(2'd3, 32'h44);
        check("full_cv", 64'(commit_valid), 64'(1));
        check("full_no_bypass", 64'(alloc_ready), 64'(0));
        commit_ready = 1'b1;
        step();
        commit_ready = 1'b0;
        check("full_ready_after_commit", 64'(alloc_ready), 64'(1));
        check("full_count3", 64'(count), 64'(3));

        // Backpressure: head done but not accepted.
        do_cdb(2'd0, 32'h55);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_cv", 64'(commit_valid), 64'(1));
            check("bp_tag", 64'(commit_tag), 64'(0));
            check("bp_val", 64'(commit_value), 64'(32'h55));
        end

        // Simultaneous allocate and commit at count 2.
        commit_ready = 1'b1;
        step();
        commit_ready = 1'b0;
        do_cdb(2'd1, 32'h66);
        check("sim_count_before", 64'(count), 64'(2));
        alloc_valid  = 1'b1;
        commit_ready = 1'b1;
        step();
        alloc_valid  = 1'b0;
        commit_ready = 1'b0;
        check("sim_count", 64'(count), 64'(2));
        check("sim_head", 64'(commit_tag), 64'(2));
        check("sim_tail", 64'(alloc_tag), 64'(0));
        do_cdb(2'd1, 32'h77);
        check("sim_free_cdb_count", 64'(count), 64'(2));
        check("sim_free_cdb_cv", 64'(commit_valid), 64'(0));

        // Asynchronous reset with three entries held.
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        check("mr_count3", 64'(count), 64'(3));
        rst = 1'b1;
        #1;
        check("mr_count", 64'(count), 64'(0));
        check("mr_empty", 64'(empty), 64'(1));
        check("mr_cv", 64'(commit_valid), 64'(0));
        check("mr_alloc_tag", 64'(alloc_tag), 64'(0));
        step();
        rst = 1'b0;

        // Wrap-around rounds.
        commit_ready = 1'b1;
        for (int r = 0; r < 10; r++) begin
            check("wr_alloc_tag", 64'(alloc_tag), 64'(r % 4));
            alloc_valid = 1'b1;
            alloc_instr = 32'(r);
            step();
            alloc_valid = 1'b0;
            do_cdb(2'(r % 4), 32'h100 + 32'(r));
            check("wr_cv", 64'(commit_valid), 64'(1));
            check("wr_tag", 64'(commit_tag), 64'(r % 4));
            check("wr_val", 64'(commit_value), 64'(32'h100 + 32'(r)));
            step();
            check("wr_empty", 64'(empty), 64'(1));
        end
        commit_ready = 1'b0;

`ifdef ROB_FLUSH_EN
        alloc_valid = 1'b1;
        repeat (2) step();
        alloc_valid = 1'b0;
        do_cdb(2'd2, 32'h99);
        check("fl_cv_before", 64'(commit_valid), 64'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_count", 64'(count), 64'(0));
        check("fl_cv", 64'(commit_valid), 64'(0));
        check("fl_tag", 64'(alloc_tag), 64'(0));
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            alloc_valid  = ($urandom_range(0, 99) < 55);
            alloc_instr  = $urandom;
            alloc_dest   = 4'($urandom_range(0, 15));
            cdb_valid    = ($urandom_range(0, 99) < 60);
            cdb_tag      = 2'($urandom_range(0, 3));
            cdb_value    = $urandom;
            commit_ready = ($urandom_range(0, 99) < 60);
            rst          = ($urandom_range(0, 299) == 0);
`ifdef ROB_FLUSH_EN
            flush        = ($urandom_range(0, 199) == 0);
`endif
            step();
        end
        rst          = 1'b0;
        alloc_valid  = 1'b0;
        cdb_valid    = 1'b0;
        commit_ready = 1'b0;
`ifdef ROB_FLUSH_EN
        flush        = 1'b0;
`endif
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
